digit_entry_ctrl: RTL

//  Parametrised user-entry controller for the number-guessing game; successor to input_control.

---
 rtl/digit_entry_pkg.sv | 12 +
 rtl/button_conditioner.sv | 62 ++++++
 rtl/digit_entry_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/digit_entry_pkg.sv
// Shared types and button indices for the digit entry controller.
package digit_entry_pkg;

    typedef enum logic {EDIT, HOLD} entry_state_t;

    localparam int unsigned BTN_INC    = 0;
    localparam int unsigned BTN_DEC    = 1;
    localparam int unsigned BTN_NEXT   = 2;
    localparam int unsigned BTN_SUBMIT = 3;
    localparam int unsigned NUM_BTNS   = 4;

endpackage

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-FF synchroniser, debounce counter, rising-edge pulse.
// A level change is accepted after DEBOUNCE_CYCLES consecutive differing samples;
// the press pulse is registered so raw-to-pulse latency is 2 + DEBOUNCE_CYCLES.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreement restarts.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state and press pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/digit_entry_ctrl.sv
// User-entry controller for the number-guessing game: conditions the four buttons, edits an
// N-digit radix-R guess under a cursor and offers the submitted guess over valid/ready.
module digit_entry_ctrl
    import digit_entry_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 3,
    parameter int unsigned RADIX           = 10,
    parameter int unsigned DIGIT_W         = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          CLEAR_ON_SUBMIT = 1'b1
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic [NUM_BTNS-1:0]                                 pushbuttons,
    input  logic [$clog2(NUM_DIGITS+1)-1:0]                     max_digits,
    input  logic                                                load_en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]                       load_digits,
    output logic [NUM_DIGITS*DIGIT_W-1:0]                       display_digits,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] cursor,
    output logic                                                guess_valid,
    input  logic                                                guess_ready,
    output logic [NUM_DIGITS*DIGIT_W-1:0]                       guess_digits
);

    localparam int unsigned CUR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned VEC_W = NUM_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);
    localparam logic [DIGIT_W:0]   RADIX_EXT = (DIGIT_W + 1)'(RADIX);

    logic [NUM_BTNS-1:0] btn_pulse;

    entry_state_t        state_q, state_d;
    logic [DIGIT_W-1:0]  digits_q [NUM_DIGITS];
    logic [DIGIT_W-1:0]  digits_d [NUM_DIGITS];
    logic [CUR_W-1:0]    cursor_q, cursor_d;
    logic                guess_valid_q, guess_valid_d;
    logic [VEC_W-1:0]    guess_q, guess_d;
    logic [DIGIT_W-1:0]  load_val;
    int unsigned         active_cnt;
    logic                cursor_oob;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (pushbuttons[b]),
            .pulse  (btn_pulse[b])
        );
    end

    // Active digit count, clamped to 1..NUM_DIGITS, and cursor range check.
    always_comb begin
        active_cnt = 32'(max_digits);
        if (active_cnt == 0) begin
            active_cnt = 1;
        end else if (active_cnt > NUM_DIGITS) begin
            active_cnt = NUM_DIGITS;
        end
        cursor_oob = (32'(cursor_q) >= active_cnt);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EDIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an accepted submit enters HOLD, the handshake returns to EDIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EDIT: begin
                if (!cursor_oob && !load_en && btn_pulse[BTN_SUBMIT]) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (guess_valid_q && guess_ready) begin
                    state_d = EDIT;
                end
            end
            default: state_d = EDIT;
        endcase
    end

    // Edit actions in priority order: out-of-range cursor, load, submit, next, inc/dec.
    always_comb begin
        digits_d      = digits_q;
        cursor_d      = cursor_q;
        guess_valid_d = guess_valid_q;
        guess_d       = guess_q;
        load_val      = '0;
        case (state_q)
            EDIT: begin
                if (cursor_oob) begin
                    cursor_d = '0;
                end else if (load_en) begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        load_val    = load_digits[i*DIGIT_W +: DIGIT_W];
                        digits_d[i] = ({1'b0, load_val} >= RADIX_EXT) ? DIGIT_MAX : load_val;
                    end
                    cursor_d = '0;
                end else if (btn_pulse[BTN_SUBMIT]) begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        guess_d[i*DIGIT_W +: DIGIT_W] = (i < active_cnt) ? digits_q[i] : '0;
                    end
                    guess_valid_d = 1'b1;
                end else if (btn_pulse[BTN_NEXT]) begin
                    cursor_d = (32'(cursor_q) == active_cnt - 1) ? '0 : cursor_q + 1'b1;
                end else if (btn_pulse[BTN_INC] != btn_pulse[BTN_DEC]) begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (32'(cursor_q) == i) begin
                            if (btn_pulse[BTN_INC]) begin
                                digits_d[i] = (digits_q[i] == DIGIT_MAX) ? '0 : digits_q[i] + 1'b1;
                            end else begin
                                digits_d[i] = (digits_q[i] == '0) ? DIGIT_MAX : digits_q[i] - 1'b1;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                // Buttons and load are dropped here; only the handshake matters.
                if (guess_valid_q && guess_ready) begin
                    guess_valid_d = 1'b0;
                    if (CLEAR_ON_SUBMIT) begin
                        digits_d = '{default: '0};
                        cursor_d = '0;
                    end
                end
                if (cursor_oob) begin
                    cursor_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Digit, cursor and guess registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digits_q      <= '{default: '0};
            cursor_q      <= '0;
            guess_valid_q <= 1'b0;
            guess_q       <= '0;
        end else begin
            digits_q      <= digits_d;
            cursor_q      <= cursor_d;
            guess_valid_q <= guess_valid_d;
            guess_q       <= guess_d;
        end
    end

    // Flatten the stored digits for display, digit 0 in the LSBs.
    always_comb begin
        display_digits = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            display_digits[i*DIGIT_W +: DIGIT_W] = digits_q[i];
        end
    end

    assign cursor       = cursor_q;
    assign guess_valid  = guess_valid_q;
    assign guess_digits = guess_q;

endmodule
